// File: rtl/game_link_pkg.sv
// Shared game-state link definitions: framing constants, packet layout,
// and FSM state types for both ends of the serial link.
package game_link_pkg;

   localparam int          DEF_CLK_HZ   = 100_000_000;
   localparam int          DEF_BAUD     = 115_200;
   localparam int          PKT_BYTES    = 22;
   localparam int          PKT_W        = PKT_BYTES * 8;
   localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
   localparam int          TIMEOUT_BITS = 32;

   localparam int PX_MSB      = 175;
   localparam int PX_LSB      = 168;
   localparam int PY_MSB      = 167;
   localparam int PY_LSB      = 160;
   localparam int WAVE_ROWS   = 3;
   localparam int WAVE_ROW_W  = 48;
   localparam int WAVE_BF_W   = 40;

   // Each wave row is a y byte followed by a 40-bit bitfield; [15:0] reserved.
   function automatic int wave_y_lsb(input int row);
      return 152 - WAVE_ROW_W * row;
   endfunction

   function automatic int wave_bf_lsb(input int row);
      return 112 - WAVE_ROW_W * row;
   endfunction

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } byte_state_e;

   typedef enum logic [1:0] {
      P_HUNT,
      P_PAYLOAD,
      P_CHECK
   } pkt_state_e;

endpackage

// File: rtl/game_packet_rx_if.sv
// Serial line plus validated-packet outputs of the game-state receiver.
interface game_packet_rx_if;
   import game_link_pkg::*;

   logic             RxD;
   logic [PKT_W-1:0] packet;
   logic             packet_valid;
   logic             chk_err;
   logic             frame_err;

   modport master (
      output RxD,
      input  packet, packet_valid, chk_err, frame_err
   );

   modport slave (
      input  RxD,
      output packet, packet_valid, chk_err, frame_err
   );

endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver with 2-flop input synchronizer; centre-sampled bits,
// single-cycle byte_valid / byte_err strobes.
module uart_byte_rx
   import game_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       byte_err_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);

   logic        sync1_q, sync2_q;
   byte_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  sh_q, sh_d;
   logic        armed_q, armed_d;
   logic        rx;

   assign rx     = sync2_q;
   assign byte_o = sh_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= B_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      sh_d         = sh_q;
      armed_d      = armed_q;
      byte_valid_o = 1'b0;
      byte_err_o   = 1'b0;
      unique case (state_q)
         // Only a high-to-low edge starts a byte, so a stuck-low line is silent.
         B_IDLE: begin
            if (rx) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               armed_d = 1'b0;
               state_d = B_START;
               cnt_d   = HALF_LD;
            end
         end
         B_START: begin
            if (cnt_q == '0) begin
               if (rx) begin
                  state_d = B_IDLE;
               end else begin
                  state_d = B_DATA;
                  cnt_d   = FULL_LD;
                  bit_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         B_DATA: begin
            if (cnt_q == '0) begin
               sh_d  = {rx, sh_q[7:1]};
               cnt_d = FULL_LD;
               if (bit_q == 3'd7) begin
                  state_d = B_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         B_STOP: begin
            if (cnt_q == '0) begin
               state_d      = B_IDLE;
               byte_valid_o = rx;
               byte_err_o   = ~rx;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = B_IDLE;
      endcase
   end

endmodule

// File: rtl/game_packet_rx.sv
// Game-state packet receiver: sync hunt, payload shift/XOR, checksum
// verification and inter-byte timeout on top of the UART byte receiver.
module game_packet_rx #(
   parameter int         CLK_HZ       = game_link_pkg::DEF_CLK_HZ,
   parameter int         BAUD         = game_link_pkg::DEF_BAUD,
   parameter int         PKT_BYTES    = game_link_pkg::PKT_BYTES,
   parameter logic [7:0] SYNC_BYTE    = game_link_pkg::SYNC_BYTE,
   parameter int         TIMEOUT_BITS = game_link_pkg::TIMEOUT_BITS
) (
   input logic             clk,
   input logic             rst,
   game_packet_rx_if.slave bus
);
   import game_link_pkg::*;

   localparam int CPB    = CLK_HZ / BAUD;
   localparam int TO_CYC = TIMEOUT_BITS * CPB;
   localparam int TW     = $clog2(TO_CYC + 1);
   localparam int IW     = $clog2(PKT_BYTES + 1);
   localparam int W      = PKT_BYTES * 8;
   localparam logic [IW-1:0] LAST_IDX = IW'(PKT_BYTES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_err;

   pkt_state_e state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]  acc_q, acc_d;
   logic [W-1:0] sr_q, sr_d;
   logic [W-1:0] pkt_q, pkt_d;
   logic [TW-1:0] idle_q, idle_d;
   logic pv_q, pv_d, ce_q, ce_d, fe_q, fe_d;
   logic timeout;

   uart_byte_rx #(
      .CLKS_PER_BIT(CPB)
   ) u_rx (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (bus.RxD),
      .byte_o      (rx_byte),
      .byte_valid_o(rx_valid),
      .byte_err_o  (rx_err)
   );

   assign bus.packet       = pkt_q;
   assign bus.packet_valid = pv_q;
   assign bus.chk_err      = ce_q;
   assign bus.frame_err    = fe_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= P_HUNT;
         idx_q   <= '0;
         acc_q   <= '0;
         sr_q    <= '0;
         pkt_q   <= '0;
         idle_q  <= '0;
         pv_q    <= 1'b0;
         ce_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         sr_q    <= sr_d;
         pkt_q   <= pkt_d;
         idle_q  <= idle_d;
         pv_q    <= pv_d;
         ce_q    <= ce_d;
         fe_q    <= fe_d;
      end
   end

   assign timeout = (idle_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      sr_d    = sr_q;
      pkt_d   = pkt_q;
      pv_d    = 1'b0;
      ce_d    = 1'b0;
      fe_d    = 1'b0;
      idle_d  = (state_q == P_HUNT || rx_valid) ? '0 : idle_q + 1'b1;
      unique case (state_q)
         P_HUNT: begin
            if (rx_valid && rx_byte == SYNC_BYTE) begin
               state_d = P_PAYLOAD;
               idx_d   = '0;
               acc_d   = '0;
            end
         end
         P_PAYLOAD: begin
            if (rx_err || (!rx_valid && timeout)) begin
               fe_d    = 1'b1;
               state_d = P_HUNT;
            end else if (rx_valid) begin
               sr_d  = {sr_q[W-9:0], rx_byte};
               acc_d = acc_q ^ rx_byte;
               if (idx_q == LAST_IDX) begin
                  state_d = P_CHECK;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         P_CHECK: begin
            if (rx_err || (!rx_valid && timeout)) begin
               fe_d    = 1'b1;
               state_d = P_HUNT;
            end else if (rx_valid) begin
               state_d = P_HUNT;
               if (rx_byte == acc_q) begin
                  pkt_d = sr_q;
                  pv_d  = 1'b1;
               end else begin
                  ce_d = 1'b1;
               end
            end
         end
         default: state_d = P_HUNT;
      endcase
   end

endmodule
